// File: rtl/audio_sample_fifo_ctrl.sv
// Sample FIFO controller around a 2048x16 simple-dual-port RAM with 1-cycle read latency.
// Define AUDIO_FIFO_STATUS_EN to add saturating overflow/underflow event counters.
module audio_sample_fifo_ctrl #(
   parameter int unsigned ADDR_W   = 11,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned AFULL_TH = 1536
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              ram_cea,
   output logic [ADDR_W-1:0] ram_ada,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_ceb,
   output logic [ADDR_W-1:0] ram_adb,
   output logic              ram_oce,
   output logic              ram_reset,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [ADDR_W+1:0] level,
   output logic              empty,
   output logic              full,
`ifdef AUDIO_FIFO_STATUS_EN
   output logic [15:0]       ovf_cnt,
   output logic [15:0]       unf_cnt,
`endif
   output logic              almost_full
);

   localparam int unsigned PW = ADDR_W + 1;
   localparam int unsigned LW = ADDR_W + 2;
   localparam logic [PW-1:0] DepthP = PW'(1 << ADDR_W);

   logic              rst_any;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_cnt;
   logic              pend_q, pend_d;
   logic [1:0]        obuf_cnt_q, obuf_cnt_d;
   logic [DATA_W-1:0] head_q, head_d, skid_q, skid_d;
   logic [LW-1:0]     level_q, level_d;
   logic              can_push, push, pop, issue;
   logic [2:0]        occ;

   assign rst_any  = reset | clear;
   assign ram_cnt  = wr_ptr_q - rd_ptr_q;
   assign can_push = (ram_cnt != DepthP);

   // Outputs are forced to their idle values while reset/clear is held.
   assign in_ready    = rst_any | can_push;
   assign out_valid   = ~rst_any & (obuf_cnt_q != 2'd0);
   assign out_data    = rst_any ? '0 : head_q;
   assign level       = rst_any ? '0 : level_q;
   assign empty       = (level == '0);
   assign full        = ~in_ready;
   assign almost_full = (level >= LW'(AFULL_TH));

   assign push = ~rst_any & in_valid & can_push;
   assign pop  = out_valid & out_ready;

   // Entries that will occupy the output queue once the in-flight read lands.
   assign occ   = {1'b0, obuf_cnt_q} + {2'b00, pend_q} - {2'b00, pop};
   assign issue = ~rst_any & (ram_cnt != '0) & (occ < 3'd2);

   assign ram_cea   = push;
   assign ram_ada   = wr_ptr_q[ADDR_W-1:0];
   assign ram_din   = in_data;
   assign ram_ceb   = issue;
   assign ram_adb   = rd_ptr_q[ADDR_W-1:0];
   assign ram_oce   = 1'b1;
   assign ram_reset = rst_any;

   always_comb begin
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(issue);
      pend_d     = issue;
      head_d     = head_q;
      skid_d     = skid_q;
      obuf_cnt_d = obuf_cnt_q;
      case ({pop, pend_q})
         2'b11: begin
            // Skid shifts into head before the returning sample is queued.
            if (obuf_cnt_q == 2'd2) begin
               head_d = skid_q;
               skid_d = ram_dout;
            end else begin
               head_d = ram_dout;
            end
         end
         2'b10: begin
            head_d     = skid_q;
            obuf_cnt_d = obuf_cnt_q - 2'd1;
         end
         2'b01: begin
            if (obuf_cnt_q == 2'd0) head_d = ram_dout;
            else                    skid_d = ram_dout;
            obuf_cnt_d = obuf_cnt_q + 2'd1;
         end
         default: ;
      endcase
      level_d = {1'b0, wr_ptr_d - rd_ptr_d} + LW'(pend_d) + LW'(obuf_cnt_d);
   end

   always_ff @(posedge clk) begin
      if (rst_any) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pend_q     <= 1'b0;
         obuf_cnt_q <= 2'd0;
         head_q     <= '0;
         skid_q     <= '0;
         level_q    <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         pend_q     <= pend_d;
         obuf_cnt_q <= obuf_cnt_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
         level_q    <= level_d;
      end
   end

`ifdef AUDIO_FIFO_STATUS_EN
   logic seen_q;

   // Underflow is only meaningful once the stream has started delivering samples.
   always_ff @(posedge clk) begin
      if (rst_any) begin
         ovf_cnt <= 16'h0000;
         unf_cnt <= 16'h0000;
         seen_q  <= 1'b0;
      end else begin
         if (in_valid && !in_ready && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
         if (seen_q && out_ready && !out_valid && unf_cnt != 16'hFFFF) unf_cnt <= unf_cnt + 16'd1;
         if (pop) seen_q <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_audio_sample_fifo_ctrl.sv
// Directed bench for audio_sample_fifo_ctrl with a behavioural 2048x16 RAM.
// Covers AUDIO_FIFO_STATUS_EN counters when that macro is defined.
module tb_audio_sample_fifo_ctrl;

   logic        clk = 1'b0;
   logic        reset, clear;
   logic [15:0] in_data;
   logic        in_valid, in_ready;
   logic [15:0] out_data;
   logic        out_valid, out_ready;
   logic        ram_cea, ram_ceb, ram_oce, ram_reset;
   logic [10:0] ram_ada, ram_adb;
   logic [15:0] ram_din, ram_dout;
   logic [12:0] level;
   logic        empty, full, almost_full;
`ifdef AUDIO_FIFO_STATUS_EN
   logic [15:0] ovf_cnt, unf_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   audio_sample_fifo_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .ram_cea     (ram_cea),
      .ram_ada     (ram_ada),
      .ram_din     (ram_din),
      .ram_ceb     (ram_ceb),
      .ram_adb     (ram_adb),
      .ram_oce     (ram_oce),
      .ram_reset   (ram_reset),
      .ram_dout    (ram_dout),
      .level       (level),
      .empty       (empty),
      .full        (full),
`ifdef AUDIO_FIFO_STATUS_EN
      .ovf_cnt     (ovf_cnt),
      .unf_cnt     (unf_cnt),
`endif
      .almost_full (almost_full)
   );

   logic [15:0] mem [2048];
   always @(posedge clk) begin
      if (ram_cea) mem[ram_ada] <= ram_din;
      if (ram_ceb) ram_dout <= mem[ram_adb];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      next_cycle();
      clear = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

   initial begin
      int n, tx, rx, guard;
      logic acc, do_push, do_pop;
      reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_level", level, 0);
      check_eq("rst_empty", empty, 1);
      check_eq("rst_full", full, 0);
      check_eq("rst_afull", almost_full, 0);
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_ram_reset", ram_reset, 1);
      check_eq("ram_oce", ram_oce, 1);
      next_cycle();
      reset = 1'b0;

      // Four back-to-back samples: valid in cycle 3, data 1..4, then drained.
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         in_valid = (c < 4);
         in_data  = 16'(c + 1);
         @(negedge clk);
         check_eq("t1_valid", out_valid, (c >= 3 && c <= 6));
         if (c >= 3 && c <= 6) check_eq("t1_data", out_data, c - 2);
         next_cycle();
      end
      @(negedge clk);
      check_eq("t1_level", level, 0);
      check_eq("t1_empty", empty, 1);
      next_cycle();

      // Fill to DEPTH + 2 with the consumer stalled.
      out_ready = 1'b0;
      n = 0; guard = 0;
      in_valid = 1'b1; in_data = 16'd0;
      while (n < 2050 && guard < 5000) begin
         @(negedge clk);
         acc = in_ready;
         next_cycle();
         if (acc) begin
            n++;
            if (n == 1535) check_eq("afull_below", almost_full, 0);
            if (n == 1536) check_eq("afull_at_th", almost_full, 1);
         end
         in_data = n[15:0];
         guard++;
      end
      in_valid = 1'b0;
      check_eq("fill_count", n, 2050);
      @(negedge clk);
      check_eq("full_level", level, 2050);
      check_eq("full_flag", full, 1);
      check_eq("full_in_ready", in_ready, 0);
      check_eq("full_afull", almost_full, 1);
      check_eq("full_head", out_data, 0);
      next_cycle();

`ifdef AUDIO_FIFO_STATUS_EN
      in_valid = 1'b1;
      repeat (3) next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("ovf_cnt_3", ovf_cnt, 3);
      check_eq("ovf_level", level, 2050);
      next_cycle();
`endif

      // One pop from full: refill read frees a RAM slot for the next cycle.
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("pop_valid", out_valid, 1);
      check_eq("pop_data", out_data, 0);
      check_eq("pop_in_ready_same", in_ready, 0);
      next_cycle();
      out_ready = 1'b0;
      @(negedge clk);
      check_eq("pop_in_ready_next", in_ready, 1);
      check_eq("pop_level", level, 2049);
      check_eq("pop_next_head", out_data, 1);
      next_cycle();

      pulse_clear();
      @(negedge clk);
      check_eq("clr1_level", level, 0);
      next_cycle();

      // Ramp stream across pointer wrap with a random consumer.
      tx = 0; rx = 0; guard = 0;
      in_valid = 1'b1; in_data = 16'd0; out_ready = 1'($urandom_range(0, 1));
      while (rx < 5000 && guard < 30000) begin
         @(negedge clk);
         do_push = in_valid && in_ready;
         do_pop  = out_valid && out_ready;
         if (do_pop) begin
            check_eq("stream_data", out_data, rx[15:0]);
            rx++;
         end
         next_cycle();
         if (do_push) tx++;
         in_valid  = (tx < 5000);
         in_data   = tx[15:0];
         out_ready = 1'($urandom_range(0, 1));
         guard++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check_eq("stream_count", rx, 5000);
      @(negedge clk);
      check_eq("stream_level", level, 0);
      next_cycle();

      // Ten samples, then clear while a refill read is in flight.
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 16'(16'hA000 + i);
         next_cycle();
      end
      in_valid = 1'b0;
      repeat (4) next_cycle();
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("clr_pre_ceb", ram_ceb, 1);
      next_cycle();
      out_ready = 1'b0;
      clear     = 1'b1;
      @(negedge clk);
      check_eq("clr_during_level", level, 0);
      check_eq("clr_during_ram_reset", ram_reset, 1);
      next_cycle();
      clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("clr_out_valid", out_valid, 0);
         check_eq("clr_level", level, 0);
         check_eq("clr_empty", empty, 1);
         next_cycle();
      end

      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      check_eq("final_level", level, 0);
`ifdef AUDIO_FIFO_STATUS_EN
      check_eq("ovf_after_reset", ovf_cnt, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
